pool_window_sequencer: RTL
==========================

# pool_window_sequencer

Controller for the binary max-pooling path of the accelerator. It latches the pooling configuration written through the AXI-Lite control registers and walks every k×k window of the ifmap buffer (BRAM, one packed channel word per pixel, 1-cycle read latency). It OR-reduces each window, which is binary max-pool across all channels in parallel, and streams one word per ofmap pixel on a valid/ready output. It sits between the control-register block and the output AXIS packer.

## Interface
- DATA_WIDTH, 32, channel bits per pixel word (bit c = channel c)
- ADDR_WIDTH, 12, ifmap BRAM address width (matches BRAM_ADDRESS_WIDTH)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- cfg_kernel_size  in  3  k, legal 1..5
- cfg_stride  in  3  s, legal 1..7
- cfg_ofmaps_width  in  9  W, legal 1..511; ofmap is W×W
- cfg_base_addr  in  ADDR_WIDTH  BRAM address of ifmap pixel (0,0)
- start  in  1  one-cycle request, sampled only in IDLE
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at end of job (normal or error)
- err  out  1  one-cycle pulse coincident with done on rejected config
- rd_en  out  1  BRAM read enable
- rd_addr  out  ADDR_WIDTH  BRAM read address
- rd_data  in  DATA_WIDTH  BRAM data, valid the cycle after rd_en
- m_valid  out  1  output pixel valid
- m_data  out  DATA_WIDTH  OR of the k×k window words
- m_last  out  1  high with the final (W×W-th) pixel
- m_ready  in  1  downstream accept

## Operation
- Ifmap width IW = (W−1)·s + k; ifmap is IW×IW, row-major from cfg_base_addr.
- FSM states: IDLE, CALC, READ, WAIT, OUT, DONE.
- IDLE: on start, latch all cfg_* and go to CALC. start is ignored in every other state, and cfg_* changes after latching have no effect.
- CALC (1 cycle): compute IW and row_step = s·IW. Config is illegal if k∉1..5, s=0, W=0, or cfg_base_addr + IW·IW > 2^ADDR_WIDTH. Illegal config → DONE with err, and no reads are issued. Legal config → READ with ox=oy=0, win_base=cfg_base_addr.
- READ (k·k cycles): rd_en=1, rd_addr = win_base + ky·IW + kx, with kx fastest. The accumulator loads the first returned word and ORs in the rest.
- WAIT (1 cycle): absorb the last read data → OUT.
- OUT: m_valid=1 and m_data=acc, both held stable until m_ready. On the handshake, advance: ox+1 and win_base += s. At ox=W−1, set ox=0, oy+1 and win_base = row_base + row_step. After the last pixel → DONE, else → READ.
- DONE (1 cycle): done=1 (err if rejected) → IDLE.
- Address arithmetic is ADDR_WIDTH unsigned. No wrap is possible on a legal config because of the CALC check.

## Timing
- Reset: state IDLE; busy, done, err, rd_en, m_valid, m_last = 0; rd_addr, m_data = 0; all counters 0.
- start sampled at cycle n → CALC at n+1 → first rd_en at n+2.
- Per pixel, without backpressure: k·k + 2 cycles (READ k·k, WAIT 1, OUT 1). With m_ready always high, a job takes 2 + W²·(k²+2) + 1 cycles from start to done.
- m_valid is asserted at the cycle after WAIT and never drops without a handshake. m_last is asserted only together with m_valid.
- No reads are issued while in OUT, so backpressure needs no read buffering.
- rst asserted mid-job aborts immediately: no done, no err, outputs return to reset values on the next edge.
- done and the final handshake never coincide. done follows the last handshake by exactly 1 cycle.

## Structure
- Shared package pool_pkg holds the state enum, K_MIN=1, K_MAX=5, S_MAX=7, and the IW-width constant (12 bits).
- Sub-module pool_addr_gen holds the kx/ky/ox/oy counters, win_base/row_base and the rd_addr adder. The top holds the FSM, accumulator and output register.

## Test plan
- 6×6, 2 channels, k=2, s=2, W=3, base 0; ch0 rows 000000/001010/010100/110000/101100/001010 in bit0, ch1 rows 000110/000000/010000/100000/110101/011101 in bit1 → m_data sequence 0,3,3,3,1,0,3,3,3; m_last on the 9th; done 1 cycle later.
- Same job with m_ready toggling every other cycle → identical data sequence; m_data stable while m_valid && !m_ready; no rd_en during OUT.
- k=1, s=1, W=4, base 100 → rd_addr 100..115 in order, m_data equals each word, 3 cycles per pixel.
- Illegal configs (k=0, k=6, s=0, W=0, base+IW² > 4096) → done and err at start+2, rd_en never high, m_valid never high.
- start pulsed while busy, and cfg_* changed mid-job → ignored; output matches the originally latched config.
- rst asserted during READ of pixel 2 → all outputs 0 next cycle, no done; a fresh start then runs a full correct job.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared definitions for the binary max-pooling window sequencer.
//   state_t      - controller FSM states
//   K_MIN/K_MAX  - legal kernel size range
//   S_MAX        - largest stride the configuration port can express
//   IW_W         - width of the ifmap-width (IW) arithmetic
//   ifmap_width  - IW = (W-1)*s + k
package pool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_READ = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [2:0] K_MIN = 3'd1;
    localparam logic [2:0] K_MAX = 3'd5;
    localparam logic [2:0] S_MAX = 3'd7;

    // Field widths of the configuration words, derived from their legal ranges.
    localparam int K_W  = $clog2(int'(K_MAX) + 1);
    localparam int S_W  = $clog2(int'(S_MAX) + 1);
    localparam int W_W  = 9;
    localparam int IW_W = 12;

    // Ifmap side length for a W x W ofmap; only meaningful when W >= 1.
    function automatic logic [IW_W-1:0] ifmap_width(
        input logic [W_W-1:0] w,
        input logic [S_W-1:0] s,
        input logic [K_W-1:0] k
    );
        logic [IW_W-1:0] wm1;
        wm1 = IW_W'(w) - IW_W'(1);
        return IW_W'(wm1 * IW_W'(s)) + IW_W'(k);
    endfunction

endpackage

// File: rtl/pool_window_sequencer_if.sv
// pool_window_sequencer_if: bus bundle of the pooling sequencer.
//   BRAM read port : rd_en, rd_addr (sequencer -> BRAM), rd_data (BRAM -> sequencer)
//   output stream  : m_valid, m_data, m_last (sequencer -> packer), m_ready (packer -> sequencer)
//   master modport is the sequencer side, slave modport the memory/packer side.
interface pool_window_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output rd_en, rd_addr, m_valid, m_data, m_last,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_en, rd_addr, m_valid, m_data, m_last,
        output rd_data, m_ready
    );
endinterface

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: window/tap address walker for the pooling sequencer.
//   clk, rst      - clock, synchronous active-high reset
//   init          - load the first window at base
//   step          - advance to the next tap inside the window (kx fastest)
//   adv           - advance to the next output pixel's window
//   k, s, w       - latched kernel size, stride, ofmap width
//   base          - latched ifmap base address
//   iw, row_step  - ifmap width and s*IW, valid from the first READ cycle
//   rd_addr       - registered BRAM address of the current tap
//   tap_first/tap_last - current tap is the first/last of the window
//   px_last       - current window is the final ofmap pixel
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  step,
    input  logic                  adv,
    input  logic [K_W-1:0]        k,
    input  logic [S_W-1:0]        s,
    input  logic [W_W-1:0]        w,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [IW_W-1:0]       iw,
    input  logic [ADDR_WIDTH-1:0] row_step,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  tap_first,
    output logic                  tap_last,
    output logic                  px_last
);

    logic [K_W-1:0]        kx_r;
    logic [K_W-1:0]        ky_r;
    logic [W_W-1:0]        ox_r;
    logic [W_W-1:0]        oy_r;
    logic [ADDR_WIDTH-1:0] win_base_r;
    logic [ADDR_WIDTH-1:0] row_base_r;
    logic [ADDR_WIDTH-1:0] line_r;      // address of tap (ky, 0) of the current window
    logic [ADDR_WIDTH-1:0] rd_addr_r;

    logic                  kx_end_s;
    logic                  row_end_s;
    logic [ADDR_WIDTH-1:0] next_line_s;
    logic [ADDR_WIDTH-1:0] next_win_s;

    assign kx_end_s    = (kx_r == k - K_W'(1));
    assign row_end_s   = (ox_r == w - W_W'(1));
    assign tap_first   = (kx_r == {K_W{1'b0}}) && (ky_r == {K_W{1'b0}});
    assign tap_last    = kx_end_s && (ky_r == k - K_W'(1));
    assign px_last     = row_end_s && (oy_r == w - W_W'(1));
    assign next_line_s = line_r + ADDR_WIDTH'(iw);
    // End of an ofmap row jumps from the row's first window by s*IW; otherwise slide right by s.
    assign next_win_s  = row_end_s ? (row_base_r + row_step) : (win_base_r + ADDR_WIDTH'(s));
    assign rd_addr     = rd_addr_r;

    // Tap and window counters; rd_addr is updated incrementally instead of via ky*IW.
    always_ff @(posedge clk) begin
        if (rst) begin
            kx_r       <= {K_W{1'b0}};
            ky_r       <= {K_W{1'b0}};
            ox_r       <= {W_W{1'b0}};
            oy_r       <= {W_W{1'b0}};
            win_base_r <= {ADDR_WIDTH{1'b0}};
            row_base_r <= {ADDR_WIDTH{1'b0}};
            line_r     <= {ADDR_WIDTH{1'b0}};
            rd_addr_r  <= {ADDR_WIDTH{1'b0}};
        end else if (init) begin
            kx_r       <= {K_W{1'b0}};
            ky_r       <= {K_W{1'b0}};
            ox_r       <= {W_W{1'b0}};
            oy_r       <= {W_W{1'b0}};
            win_base_r <= base;
            row_base_r <= base;
            line_r     <= base;
            rd_addr_r  <= base;
        end else if (step) begin
            if (kx_end_s) begin
                kx_r      <= {K_W{1'b0}};
                ky_r      <= ky_r + K_W'(1);
                line_r    <= next_line_s;
                rd_addr_r <= next_line_s;
            end else begin
                kx_r      <= kx_r + K_W'(1);
                rd_addr_r <= rd_addr_r + ADDR_WIDTH'(1);
            end
        end else if (adv) begin
            kx_r       <= {K_W{1'b0}};
            ky_r       <= {K_W{1'b0}};
            win_base_r <= next_win_s;
            line_r     <= next_win_s;
            rd_addr_r  <= next_win_s;
            if (row_end_s) begin
                ox_r       <= {W_W{1'b0}};
                oy_r       <= oy_r + W_W'(1);
                row_base_r <= next_win_s;
            end else begin
                ox_r <= ox_r + W_W'(1);
            end
        end
    end

endmodule

// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer: walks every k x k window of the ifmap BRAM, OR-reduces
// the packed channel words of each window and streams one word per ofmap pixel.
//   clk, rst              - clock, synchronous active-high reset
//   cfg_kernel_size (k)   - 1..5
//   cfg_stride (s)        - 1..7
//   cfg_ofmaps_width (W)  - 1..511, ofmap is W x W
//   cfg_base_addr         - BRAM address of ifmap pixel (0,0)
//   start                 - job request, sampled only when idle
//   busy, done, err       - job status; err pulses with done on a rejected config
//   bus (master)          - BRAM read port and valid/ready output stream
module pool_window_sequencer
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [K_W-1:0]        cfg_kernel_size,
    input  logic [S_W-1:0]        cfg_stride,
    input  logic [W_W-1:0]        cfg_ofmaps_width,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    pool_window_sequencer_if.master bus
);

    localparam logic [2*IW_W:0] ADDR_SPAN = (2*IW_W+1)'(1) << ADDR_WIDTH;

    state_t                state_r;
    logic [K_W-1:0]        k_r;
    logic [S_W-1:0]        s_r;
    logic [W_W-1:0]        w_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [IW_W-1:0]       iw_r;
    logic [ADDR_WIDTH-1:0] row_step_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic                  rd_en_r;
    logic                  m_valid_r;
    logic                  m_last_r;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic [DATA_WIDTH-1:0] acc_r;
    logic                  rd_valid_r;  // rd_data carries a window word this cycle
    logic                  first_q_r;   // that word is the window's first tap

    logic [IW_W-1:0]       iw_s;
    logic [2*IW_W-1:0]     iw_sq_s;
    logic [2*IW_W:0]       area_end_s;
    logic [ADDR_WIDTH-1:0] row_step_s;
    logic                  cfg_bad_s;
    logic                  init_s;
    logic                  step_s;
    logic                  adv_s;
    logic                  hs_s;
    logic [DATA_WIDTH-1:0] acc_next_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic                  tap_first_s;
    logic                  tap_last_s;
    logic                  px_last_s;

    // The ifmap must fit below the top of the address space so no address can wrap.
    assign iw_s       = ifmap_width(w_r, s_r, k_r);
    assign iw_sq_s    = (2*IW_W)'(iw_s) * (2*IW_W)'(iw_s);
    assign area_end_s = (2*IW_W+1)'(base_r) + (2*IW_W+1)'(iw_sq_s);
    assign row_step_s = ADDR_WIDTH'(iw_s * IW_W'(s_r));
    assign cfg_bad_s  = (k_r < K_MIN) || (k_r > K_MAX) || (s_r == {S_W{1'b0}}) ||
                        (w_r == {W_W{1'b0}}) || (area_end_s > ADDR_SPAN);

    assign hs_s       = (state_r == ST_OUT) && bus.m_ready;
    assign init_s     = (state_r == ST_CALC) && !cfg_bad_s;
    assign step_s     = (state_r == ST_READ) && !tap_last_s;
    assign adv_s      = hs_s && !px_last_s;
    assign acc_next_s = first_q_r ? bus.rd_data : (acc_r | bus.rd_data);

    pool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .init      (init_s),
        .step      (step_s),
        .adv       (adv_s),
        .k         (k_r),
        .s         (s_r),
        .w         (w_r),
        .base      (base_r),
        .iw        (iw_r),
        .row_step  (row_step_r),
        .rd_addr   (rd_addr_s),
        .tap_first (tap_first_s),
        .tap_last  (tap_last_s),
        .px_last   (px_last_s)
    );

    // Controller FSM with registered status, read-enable and output-stream signals.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            k_r        <= {K_W{1'b0}};
            s_r        <= {S_W{1'b0}};
            w_r        <= {W_W{1'b0}};
            base_r     <= {ADDR_WIDTH{1'b0}};
            iw_r       <= {IW_W{1'b0}};
            row_step_r <= {ADDR_WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            rd_en_r    <= 1'b0;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
            m_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (start) begin
                        k_r     <= cfg_kernel_size;
                        s_r     <= cfg_stride;
                        w_r     <= cfg_ofmaps_width;
                        base_r  <= cfg_base_addr;
                        busy_r  <= 1'b1;
                        state_r <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    iw_r       <= iw_s;
                    row_step_r <= row_step_s;
                    if (cfg_bad_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        rd_en_r <= 1'b1;
                        state_r <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (tap_last_s) begin
                        rd_en_r <= 1'b0;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Last tap's word arrives now; fold it straight into the output register.
                    m_valid_r <= 1'b1;
                    m_data_r  <= acc_next_s;
                    m_last_r  <= px_last_s;
                    state_r   <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_r <= 1'b0;
                        m_last_r  <= 1'b0;
                        if (px_last_s) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            rd_en_r <= 1'b1;
                            state_r <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    err_r     <= 1'b0;
                    rd_en_r   <= 1'b0;
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Window accumulator: first returned word loads, later words OR in.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= {DATA_WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
            first_q_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_en_r;
            first_q_r  <= rd_en_r && tap_first_s;
            if (rd_valid_r) begin
                acc_r <= acc_next_s;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign bus.rd_en   = rd_en_r;
    assign bus.rd_addr = rd_addr_s;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;
    assign bus.m_last  = m_last_r;

endmodule
